// File: rtl/stub_pair_memory_pkg.sv
// Shared constants and types for the stub-pair memory.
package stubpair_pkg;
  localparam int DATA_WIDTH   = 12;
  localparam int PAGE_BITS    = 3;
  localparam int INDEX_BITS   = 6;
  localparam int MAX_ENTRIES  = 63;
  localparam int READ_LATENCY = 2;

  // {inner stub index[5:0], outer stub index[5:0]}
  typedef logic [DATA_WIDTH-1:0] stub_pair_t;
endpackage

// File: rtl/stub_pair_memory_ram.sv
// spm_ram: simple dual-port RAM, one write port, two-stage registered read.
// Read pipeline registers clear synchronously; array contents never reset.
module spm_ram #(
  parameter int AW = 9,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rd_q;
  logic [DW-1:0] dout_q;

  // Write port; a same-edge read of this address still sees the old word.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Array read register followed by output register.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      rd_q   <= '0;
      dout_q <= '0;
    end else begin
      rd_q   <= mem_q[raddr_i];
      dout_q <= rd_q;
    end
  end

  assign rdata_o = dout_q;
endmodule

// File: rtl/stub_pair_memory.sv
// stub_pair_memory: paged sink for tracklet-engine stub pairs.
// Optional macro STUBPAIR_MEM_OVERFLOW_EN adds a sticky overflow output and
// an internal saturating dropped-word counter.
module stub_pair_memory #(
  parameter int PAGE_BITS   = stubpair_pkg::PAGE_BITS,
  parameter int DATA_WIDTH  = stubpair_pkg::DATA_WIDTH,
  parameter int MAX_ENTRIES = stubpair_pkg::MAX_ENTRIES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              start,
  output logic [1:0]              done,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    valid_in,
  input  logic [PAGE_BITS+5:0]    read_add,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [5:0]              number_out
`ifdef STUBPAIR_MEM_OVERFLOW_EN
  ,
  output logic                    overflow
`endif
);
  import stubpair_pkg::*;

  localparam int AW     = PAGE_BITS + INDEX_BITS;
  localparam int NPAGES = 2**PAGE_BITS;
  localparam logic [INDEX_BITS-1:0] MAX_CNT = INDEX_BITS'(MAX_ENTRIES);

  typedef logic [INDEX_BITS-1:0] cnt_t;

  cnt_t                 cnt_q [NPAGES];
  cnt_t                 cnt_d [NPAGES];
  logic [PAGE_BITS-1:0] wr_page_q, wr_page_d;
  cnt_t                 wr_idx;
  logic                 rst_all, we;
  cnt_t                 number_q;
  logic [1:0]           done_q;

  // Page advance, write slot selection and next-state page counts.
  always_comb begin
    rst_all   = reset | start[1];
    wr_page_d = start[0] ? wr_page_q + 1'b1 : wr_page_q;
    // a word arriving with start[0] lands at index 0 of the new page
    wr_idx    = start[0] ? '0 : cnt_q[wr_page_q];
    we        = valid_in & ~rst_all & (wr_idx < MAX_CNT);
    cnt_d     = cnt_q;
    if (start[0]) cnt_d[wr_page_d] = '0;
    if (we)       cnt_d[wr_page_d] = wr_idx + 1'b1;
  end

  // Page counters, write pointer and count readout; start[1] acts as reset.
  always_ff @(posedge clk) begin
    if (rst_all) begin
      for (int p = 0; p < NPAGES; p++) cnt_q[p] <= '0;
      wr_page_q <= '1;
      number_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      wr_page_q <= wr_page_d;
      number_q  <= cnt_q[read_add[AW-1:INDEX_BITS]];
    end
  end

  // done echoes start one clock later; start[1] shows up as done[1].
  always_ff @(posedge clk) begin
    if (reset) done_q <= '0;
    else       done_q <= start;
  end

`ifdef STUBPAIR_MEM_OVERFLOW_EN
  logic        drop;
  logic        ovf_q;
  logic [15:0] drop_cnt_q;

  assign drop = valid_in & ~rst_all & (wr_idx >= MAX_CNT);

  // Sticky overflow flag and saturating count of dropped words.
  always_ff @(posedge clk) begin
    if (rst_all) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      ovf_q <= 1'b1;
      if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign overflow = ovf_q;
`endif

  spm_ram #(.AW(AW), .DW(DATA_WIDTH)) u_ram (
    .clk     (clk),
    .clr_i   (rst_all),
    .we_i    (we),
    .waddr_i ({wr_page_d, wr_idx}),
    .wdata_i (data_in),
    .raddr_i (read_add),
    .rdata_o (data_out)
  );

  assign number_out = number_q;
  assign done       = done_q;
endmodule
